// File: rtl/reg_file.sv
// reg_file: register file plus NZCV status register at the far end of the ALU datapath.
// Operand A is driven onto bus a, and operand B onto bus b. Both buses are tri-state.
// ALU results are captured from the result bus. Status flags are latched.
// Branch conditions are evaluated against the latched flags.
// The last register (NUM_REGS-1) is the program counter.
// Optional feature macro: REG_BYPASS_EN.
// When it is defined, a write in progress is forwarded combinationally to a read port that selects the same register.
module reg_file #(
   parameter int NUM_REGS = 16,
   parameter int WIDTH    = 32,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             oe_a,
   input  logic [SEL_W-1:0] sel_a,
   input  logic             oe_b,
   input  logic [SEL_W-1:0] sel_b,
   input  logic             ld,
   input  logic [SEL_W-1:0] sel_in,
   input  logic [WIDTH-1:0] result,
   input  logic             pc_inc,
   input  logic             status_ld,
   input  logic [3:0]       status_in,
   input  logic [3:0]       cond,
   output tri   [WIDTH-1:0] a,
   output tri   [WIDTH-1:0] b,
   output logic [3:0]       status,
   output logic             carry_out,
   output logic             cond_true
);

   localparam logic [SEL_W-1:0] PC_IDX = SEL_W'(NUM_REGS - 1);

   logic [WIDTH-1:0] r_regs [NUM_REGS];
   logic [3:0]       r_status;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;
   logic             w_pc_ld;
   logic             w_n, w_z, w_c, w_v;

   // An explicit PC load has priority over the increment.
   assign w_pc_ld = ld && (sel_in == PC_IDX);

   // Register writes.
   // A PC increment coexists with a load to any other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         if (ld) r_regs[sel_in] <= result;
         if (pc_inc && !w_pc_ld) r_regs[PC_IDX] <= r_regs[PC_IDX] + WIDTH'(1);
      end
   end

   // Status flags are latched only on status_ld. They are independent of register writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_status <= 4'b0000;
      else if (status_ld) r_status <= status_in;
   end

`ifdef REG_BYPASS_EN
   // Forward the pending write (ld only, never pc_inc) to a matching read port.
   assign w_rd_a = (ld && (sel_in == sel_a)) ? result : r_regs[sel_a];
   assign w_rd_b = (ld && (sel_in == sel_b)) ? result : r_regs[sel_b];
`else
   // Reads always return stored values; a write becomes visible after the edge.
   assign w_rd_a = r_regs[sel_a];
   assign w_rd_b = r_regs[sel_b];
`endif

   assign a = oe_a ? w_rd_a : {WIDTH{1'bz}};
   assign b = oe_b ? w_rd_b : {WIDTH{1'bz}};

   assign status    = r_status;
   assign carry_out = r_status[1];
   assign {w_n, w_z, w_c, w_v} = r_status;

   // Branch condition evaluation. It uses only the latched flags; C=1 means a borrow.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'd0:  cond_true = 1'b1;
         4'd1:  cond_true = w_z;
         4'd2:  cond_true = !w_z;
         4'd3:  cond_true = w_c;
         4'd4:  cond_true = !w_c;
         4'd5:  cond_true = w_n;
         4'd6:  cond_true = !w_n;
         4'd7:  cond_true = w_v;
         4'd8:  cond_true = !w_v;
         4'd9:  cond_true = !w_c && !w_z;
         4'd10: cond_true = w_c || w_z;
         4'd11: cond_true = (w_n == w_v);
         4'd12: cond_true = (w_n != w_v);
         4'd13: cond_true = !w_z && (w_n == w_v);
         4'd14: cond_true = w_z || (w_n != w_v);
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file and NZCV status register at the far end of the ALU datapath.
- Drives ALU operand A (data bus) and operand B (addr bus) through tri-state outputs.
- Captures ALU results from the result bus and latches ALU status flags.
- Returns the carry flag to the ALU and evaluates branch conditions for the controller.

Parameters:
- NUM_REGS, 16, number of registers; index NUM_REGS-1 is the PC (power of two, ≥4).
- WIDTH, 32, register and bus width.
- SEL_W, $clog2(NUM_REGS), register select width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- oe_a  in  1  drive register sel_a onto a.
- sel_a  in  SEL_W  read select, port A.
- oe_b  in  1  drive register sel_b onto b.
- sel_b  in  SEL_W  read select, port B.
- ld  in  1  write result into register sel_in at the next edge.
- sel_in  in  SEL_W  write select.
- result  in  WIDTH  ALU result bus.
- pc_inc  in  1  increment PC by 1 at the next edge.
- status_ld  in  1  latch status_in at the next edge.
- status_in  in  4  ALU NZCV flags.
- cond  in  4  condition code to evaluate.
- a  out(tri)  WIDTH  operand bus A; high-Z when oe_a=0.
- b  out(tri)  WIDTH  operand bus B; high-Z when oe_b=0.
- status  out  4  latched NZCV; [3]=N, [2]=Z, [1]=C, [0]=V.
- carry_out  out  1  equals status[1]; feeds ALU carry_in.
- cond_true  out  1  combinational result of evaluating cond against status.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers =0, status=4'b0000, carry_out=0. a and b still follow oe_a/oe_b: value 0 if enabled, high-Z otherwise.
- Reads are combinational: a = oe_a ? reg[sel_a] : 'z. Same rule for b. Both ports may select the same register simultaneously.
- Writes: at a rising edge with ld=1, reg[sel_in] <= result. Latency is 1 cycle.
- No write-forwarding by default: a read in the same cycle as a write returns the old value until the edge.
- PC (reg NUM_REGS-1) update per edge, in priority order:
  - ld=1 with sel_in=NUM_REGS-1: load result; pc_inc is ignored.
  - else pc_inc=1: PC <= PC+1, modulo 2^WIDTH (all-ones wraps to 0).
  - else hold.
- pc_inc with ld targeting another register: both take effect at the same edge.
- Status: at a rising edge with status_ld=1, status <= status_in; otherwise hold. ld and status_ld are independent.
- Condition codes (C=1 means borrow after subtraction):
  - 0 AL: 1
  - 1 EQ: Z
  - 2 NE: !Z
  - 3 LTU: C
  - 4 GEU: !C
  - 5 NEG: N
  - 6 POS: !N
  - 7 VS: V
  - 8 VC: !V
  - 9 GTU: !C&!Z
  - 10 LEU: C|Z
  - 11 GE: N==V
  - 12 LT: N!=V
  - 13 GT: !Z&(N==V)
  - 14 LE: Z|(N!=V)
  - 15 NV: 0
- cond_true depends only on the registered status, never on status_in.
- Reset asserted mid-cycle clears state immediately. A pending ld, pc_inc or status_ld in that cycle is discarded.
- An X/Z value on result when ld=1 is stored as-is; the bench must not rely on this.

Optional Feature:
- Macro REG_BYPASS_EN.
- Defined: when ld=1 and sel_a==sel_in with oe_a=1, a drives result instead of the stored value (same for port B). The edge write is unchanged.
- Defined, PC case: the PC bypass applies only for ld; pc_inc is never forwarded.
- Undefined: no forwarding; reads always return stored values.

Test Plan:
- Reset then oe_a=1, sel_a=5 → a=0x00000000. With oe_a=0 → a=Z. status=0000, cond=0 → cond_true=1; cond=15 → cond_true=0.
- ld=1, sel_in=3, result=0xDEADBEEF for one edge; next cycle oe_b=1, sel_b=3 → b=0xDEADBEEF. During the write cycle with sel_a=3: a=old 0 (bypass off), a=0xDEADBEEF (REG_BYPASS_EN).
- PC=0xFFFFFFFF, pc_inc=1 → PC=0x00000000. Then ld=1, sel_in=15, result=0x100 with pc_inc=1 → PC=0x100.
- status_ld=1, status_in=4'b0100 → status=0100, cond=1 → cond_true=1, cond=9 → 0. Then status_in=4'b1001 without status_ld → status unchanged.
- status=4'b0010 → carry_out=1, cond=3 → 1, cond=4 → 0, cond=10 → 1. status=4'b1000 → cond=12 → 1, cond=11 → 0, cond=14 → 1.
- Load reg 7=0x55, then assert rst_n=0 mid-cycle with ld=1, sel_in=7, result=0xAA → reg 7 reads 0 after reset and 0xAA is never stored.
